// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths and the EX/MEM payload record.
// The payload record is stored as one packed word in each skid slot.
package ex_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] alu_result;
        logic [DATA_W_DEF-1:0] store_data;
        logic [REG_W_DEF-1:0]  rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  branch;
        logic                  branch_ne;
        logic [DATA_W_DEF-1:0] branch_target;
    } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_skid_slot.sv
// skid_slot: one valid bit plus one payload register.
//   clk, rst  : clock, asynchronous active-high reset
//   valid_d   : next value of the valid bit (written every cycle)
//   load      : payload load enable; payload holds when low
//   data_d    : payload to capture on load
//   valid_q   : registered valid bit
//   data_q    : registered payload (zero after reset)
module skid_slot
    import ex_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_d,
    input  logic          load,
    input  ex_mem_entry_t data_d,
    output logic          valid_q,
    output ex_mem_entry_t data_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= data_d;
            end
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry skid buffer / pipeline register between EX and MEM,
// with beq/bne resolution producing a registered one-cycle branch pulse.
//   clk, rst              : clock, asynchronous active-high reset
//   flush                 : synchronous kill of both entries and any accept
//   in_valid / in_ready   : EX-side handshake (in_ready = no skid entry)
//   in_*                  : ALU result, Zero flag, store data, rd, control, branch info
//   out_valid / out_ready : MEM-side handshake
//   out_*                 : registered payload from the main slot
//   branch_taken          : one-cycle pulse after accepting a taken branch
//   branch_pc             : target of the last taken branch
// Optional macro EX_MEM_SKID_FORWARD_EN adds fwd_valid/fwd_rd/fwd_data, a
// combinational bypass view of the main slot for the EX stage.
module ex_mem_skid
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_mem_to_reg,
    input  logic              in_branch,
    input  logic              in_branch_ne,
    input  logic [DATA_W-1:0] in_branch_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_pc
`ifdef EX_MEM_SKID_FORWARD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    ex_mem_entry_t     in_entry;
    ex_mem_entry_t     main_data_d, main_data_q;
    ex_mem_entry_t     skid_data_q;
    logic              main_valid_d, main_valid_q, main_load;
    logic              skid_valid_d, skid_valid_q, skid_load;
    logic              accept, drain;
    logic              branch_taken_d, branch_taken_q;
    logic [DATA_W-1:0] branch_pc_d, branch_pc_q;

    always_comb begin
        in_entry               = '0;
        in_entry.alu_result    = in_alu_result;
        in_entry.store_data    = in_store_data;
        in_entry.rd            = in_rd;
        in_entry.reg_write     = in_reg_write;
        in_entry.mem_read      = in_mem_read;
        in_entry.mem_write     = in_mem_write;
        in_entry.mem_to_reg    = in_mem_to_reg;
        in_entry.branch        = in_branch;
        in_entry.branch_ne     = in_branch_ne;
        in_entry.branch_target = in_branch_target;
    end

    // in_ready comes straight from the skid valid flop, so EX never sees a
    // combinational path from out_ready.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_load    = 1'b0;
        skid_load    = 1'b0;
        main_data_d  = in_entry;
        if (flush) begin
            // A drain in this cycle already completed at MEM; just empty both.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            main_load    = 1'b1;
            main_data_d  = skid_data_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            main_load    = accept;
            main_valid_d = accept;
        end else if (accept) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    skid_slot u_main (
        .clk     (clk),
        .rst     (rst),
        .valid_d (main_valid_d),
        .load    (main_load),
        .data_d  (main_data_d),
        .valid_q (main_valid_q),
        .data_q  (main_data_q)
    );

    skid_slot u_skid (
        .clk     (clk),
        .rst     (rst),
        .valid_d (skid_valid_d),
        .load    (skid_load),
        .data_d  (in_entry),
        .valid_q (skid_valid_q),
        .data_q  (skid_data_q)
    );

    // Branches resolve on accept only; accept already excludes flush, which
    // keeps the pulse low in the cycle after a flush.
    always_comb begin
        branch_taken_d = accept & in_branch & (in_zero ^ in_branch_ne);
        branch_pc_d    = branch_taken_d ? in_branch_target : branch_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_taken_q <= 1'b0;
            branch_pc_q    <= '0;
        end else begin
            branch_taken_q <= branch_taken_d;
            branch_pc_q    <= branch_pc_d;
        end
    end

    assign out_valid      = main_valid_q;
    assign out_alu_result = main_data_q.alu_result;
    assign out_store_data = main_data_q.store_data;
    assign out_rd         = main_data_q.rd;
    assign out_reg_write  = main_data_q.reg_write;
    assign out_mem_read   = main_data_q.mem_read;
    assign out_mem_write  = main_data_q.mem_write;
    assign out_mem_to_reg = main_data_q.mem_to_reg;
    assign branch_taken   = branch_taken_q;
    assign branch_pc      = branch_pc_q;

    // Branch fields travel with the entry but are consumed at accept time.
    logic unused_branch_fields;
    assign unused_branch_fields = ^{main_data_q.branch, main_data_q.branch_ne,
                                    main_data_q.branch_target};

`ifdef EX_MEM_SKID_FORWARD_EN
    assign fwd_valid = main_valid_q & main_data_q.reg_write & (main_data_q.rd != '0);
    assign fwd_rd    = main_data_q.rd;
    assign fwd_data  = main_data_q.alu_result;
`else
    // No bypass view in this build.
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic        in_zero;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
    logic        in_branch, in_branch_ne;
    logic [31:0] in_branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result, out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
    logic        branch_taken;
    logic [31:0] branch_pc;
`ifdef EX_MEM_SKID_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_mem_skid dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_alu_result    (in_alu_result),
        .in_zero          (in_zero),
        .in_store_data    (in_store_data),
        .in_rd            (in_rd),
        .in_reg_write     (in_reg_write),
        .in_mem_read      (in_mem_read),
        .in_mem_write     (in_mem_write),
        .in_mem_to_reg    (in_mem_to_reg),
        .in_branch        (in_branch),
        .in_branch_ne     (in_branch_ne),
        .in_branch_target (in_branch_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_alu_result   (out_alu_result),
        .out_store_data   (out_store_data),
        .out_rd           (out_rd),
        .out_reg_write    (out_reg_write),
        .out_mem_read     (out_mem_read),
        .out_mem_write    (out_mem_write),
        .out_mem_to_reg   (out_mem_to_reg),
        .branch_taken     (branch_taken),
        .branch_pc        (branch_pc)
`ifdef EX_MEM_SKID_FORWARD_EN
        ,
        .fwd_valid        (fwd_valid),
        .fwd_rd           (fwd_rd),
        .fwd_data         (fwd_data)
`endif
    );

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic        zero;
        logic        br;
        logic        ne;
        logic [31:0] tgt;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_alu;
        logic        e_ir;
        logic        e_bt;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [31:0] alu, input logic zero,
                       input logic br, input logic ne, input logic [31:0] tgt,
                       input logic ordy, input logic fl, input logic e_ov,
                       input logic [31:0] e_alu, input logic e_ir, input logic e_bt,
                       input logic [31:0] e_pc);
        vec_t t;
        t.v = v; t.alu = alu; t.zero = zero; t.br = br; t.ne = ne; t.tgt = tgt;
        t.ordy = ordy; t.fl = fl; t.e_ov = e_ov; t.e_alu = e_alu; t.e_ir = e_ir;
        t.e_bt = e_bt; t.e_pc = e_pc;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_alu_result = 0; in_zero = 0; in_store_data = 0; in_rd = 0;
        in_reg_write = 0; in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0;
        in_branch = 0; in_branch_ne = 0; in_branch_target = 0; flush = 0; out_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_branch_taken", branch_taken, 0);
        chk("rst_branch_pc", branch_pc, 0);
        chk("rst_out_alu", out_alu_result, 0);
        chk("rst_out_rd", out_rd, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        //  v  alu    z  br ne tgt    ordy fl  e_ov e_alu  e_ir e_bt e_pc
        // streaming
        add(1, 32'h1, 0, 0, 0, 0,     1,   0,  1,   32'h1, 1,   0,   32'h0);
        add(1, 32'h2, 0, 0, 0, 0,     1,   0,  1,   32'h2, 1,   0,   32'h0);
        add(1, 32'h3, 0, 0, 0, 0,     1,   0,  1,   32'h3, 1,   0,   32'h0);
        add(0, 32'h7, 0, 0, 0, 0,     1,   0,  0,   32'h3, 1,   0,   32'h0);
        // back-pressure
        add(1, 32'hA, 0, 0, 0, 0,     0,   0,  1,   32'hA, 1,   0,   32'h0);
        add(1, 32'hB, 0, 0, 0, 0,     0,   0,  1,   32'hA, 0,   0,   32'h0);
        add(1, 32'hC, 0, 0, 0, 0,     0,   0,  1,   32'hA, 0,   0,   32'h0);
        add(0, 32'h0, 0, 0, 0, 0,     1,   0,  1,   32'hB, 1,   0,   32'h0);
        add(0, 32'h0, 0, 0, 0, 0,     1,   0,  0,   32'hB, 1,   0,   32'h0);
        // beq taken, then not taken
        add(1, 32'h10, 1, 1, 0, 32'h40, 1, 0,  1,   32'h10, 1,  1,   32'h40);
        add(0, 32'h0,  0, 0, 0, 0,      1, 0,  0,   32'h10, 1,  0,   32'h40);
        add(1, 32'h11, 0, 1, 0, 32'h44, 1, 0,  1,   32'h11, 1,  0,   32'h40);
        // bne taken, then not taken
        add(1, 32'h12, 0, 1, 1, 32'h80, 1, 0,  1,   32'h12, 1,  1,   32'h80);
        add(0, 32'h0,  0, 0, 0, 0,      1, 0,  0,   32'h12, 1,  0,   32'h80);
        add(1, 32'h13, 1, 1, 1, 32'h90, 1, 0,  1,   32'h13, 1,  0,   32'h80);
        add(0, 32'h0,  0, 0, 0, 0,      1, 0,  0,   32'h13, 1,  0,   32'h80);
        // fill both slots; a taken branch offered while full is not accepted
        add(1, 32'h20, 0, 0, 0, 0,      0, 0,  1,   32'h20, 1,  0,   32'h80);
        add(1, 32'h21, 0, 0, 0, 0,      0, 0,  1,   32'h20, 0,  0,   32'h80);
        add(1, 32'h22, 1, 1, 0, 32'hC0, 0, 0,  1,   32'h20, 0,  0,   32'h80);
        // flush with both full and an entry offered
        add(1, 32'h99, 0, 0, 0, 0,      0, 1,  0,   32'h20, 1,  0,   32'h80);
        add(0, 32'h0,  0, 0, 0, 0,      1, 0,  0,   32'h20, 1,  0,   32'h80);
        // flush kills an offered taken branch
        add(1, 32'h55, 1, 1, 0, 32'hF0, 1, 1,  0,   32'h20, 1,  0,   32'h80);
        add(0, 32'h0,  0, 0, 0, 0,      1, 0,  0,   32'h20, 1,  0,   32'h80);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].v; in_alu_result = vecs[i].alu; in_zero = vecs[i].zero;
            in_branch = vecs[i].br; in_branch_ne = vecs[i].ne;
            in_branch_target = vecs[i].tgt; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            tick();
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("v%0d_out_alu", i), out_alu_result, vecs[i].e_alu);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("v%0d_branch_taken", i), branch_taken, vecs[i].e_bt);
            chk($sformatf("v%0d_branch_pc", i), branch_pc, vecs[i].e_pc);
        end
        idle_inputs();

        // full payload passes through unchanged
        in_valid = 1; in_alu_result = 32'h1234_5678; in_store_data = 32'hCAFE_F00D;
        in_rd = 5'd9; in_reg_write = 0; in_mem_read = 1; in_mem_write = 1; in_mem_to_reg = 1;
        tick();
        idle_inputs();
        out_ready = 0;
        chk("pay_alu", out_alu_result, 32'h1234_5678);
        chk("pay_store", out_store_data, 32'hCAFE_F00D);
        chk("pay_rd", out_rd, 9);
        chk("pay_ctrl", {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg}, 4'b0111);
        tick();
        out_ready = 1;
        tick();
        chk("pay_drained", out_valid, 0);

`ifdef EX_MEM_SKID_FORWARD_EN
        in_valid = 1; in_alu_result = 32'h77; in_rd = 5'd0; in_reg_write = 1; out_ready = 0;
        tick();
        chk("fwd_rd0_valid", fwd_valid, 0);
        chk("fwd_rd0_out_valid", out_valid, 1);
        idle_inputs();
        tick();
        in_valid = 1; in_alu_result = 32'h88; in_rd = 5'd6; in_reg_write = 1;
        tick();
        idle_inputs();
        out_ready = 0;
        chk("fwd_valid", fwd_valid, 1);
        chk("fwd_rd", fwd_rd, 6);
        chk("fwd_data", fwd_data, 32'h88);
        flush = 1;
        tick();
        flush = 0;
        chk("fwd_after_flush", fwd_valid, 0);
        out_ready = 1;
`endif

        // async reset between edges while an entry and a branch pulse are live
        in_valid = 1; in_alu_result = 32'h66; in_branch = 1; in_zero = 1;
        in_branch_target = 32'h100; in_rd = 5'd4; in_reg_write = 1; out_ready = 0;
        tick();
        in_valid = 1; in_branch = 0; in_alu_result = 32'h67;
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_branch_taken", branch_taken, 1);
        chk("pre_rst_branch_pc", branch_pc, 32'h100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_branch_taken", branch_taken, 0);
        chk("async_rst_branch_pc", branch_pc, 0);
        chk("async_rst_in_ready", in_ready, 1);
`ifdef EX_MEM_SKID_FORWARD_EN
        chk("async_rst_fwd_valid", fwd_valid, 0);
`endif
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1; in_alu_result = 32'h5;
        tick();
        idle_inputs();
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_alu", out_alu_result, 32'h5);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
